// File: rtl/vga_reg_update_sched_pkg.sv
// Shared definitions for the VGA display-register update scheduler.
//   NUM_REGS / ADDR_W : default register count and address width
//   SEG_R .. CURSOR   : display register addresses (1-based, 0 is unused)
//   sched_state_e     : stream scheduler FSM states
package vga_reg_update_sched_pkg;

    localparam int NUM_REGS = 12;
    localparam int ADDR_W   = 4;

    localparam logic [3:0] SEG_R    = 4'd1;
    localparam logic [3:0] SEG_G    = 4'd2;
    localparam logic [3:0] SEG_B    = 4'd3;
    localparam logic [3:0] HOUR     = 4'd4;
    localparam logic [3:0] MIN      = 4'd5;
    localparam logic [3:0] SEC      = 4'd6;
    localparam logic [3:0] TMR_HOUR = 4'd7;
    localparam logic [3:0] TMR_MIN  = 4'd8;
    localparam logic [3:0] TMR_SEC  = 4'd9;
    localparam logic [3:0] FLAGS    = 4'd10;
    localparam logic [3:0] BLINK    = 4'd11;
    localparam logic [3:0] CURSOR   = 4'd12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/vga_reg_update_sched_if.sv
// Bus bundle for the display-register update scheduler.
//   RTC_*      : clock-reader write port (WE/ADDR/DATA in, ACK out)
//   UI_*       : user-edit write port (WE/ADDR/DATA in, ACK out)
//   VSync      : active-low sync, low = update window
//   MemAddrOUT / MemDataOUT / CS_DATA : write stream to display pointer block
//   BUSY       : any shadow entry still waiting to be sent
// master = the side issuing writes and VSync, slave = the scheduler.
interface vga_reg_update_sched_if #(
    parameter int ADDR_W = 4
);
    logic              RTC_WE;
    logic [ADDR_W-1:0] RTC_ADDR;
    logic [7:0]        RTC_DATA;
    logic              RTC_ACK;
    logic              UI_WE;
    logic [ADDR_W-1:0] UI_ADDR;
    logic [7:0]        UI_DATA;
    logic              UI_ACK;
    logic              VSync;
    logic [ADDR_W-1:0] MemAddrOUT;
    logic [7:0]        MemDataOUT;
    logic              CS_DATA;
    logic              BUSY;

    modport master (
        output RTC_WE, RTC_ADDR, RTC_DATA, UI_WE, UI_ADDR, UI_DATA, VSync,
        input  RTC_ACK, UI_ACK, MemAddrOUT, MemDataOUT, CS_DATA, BUSY
    );

    modport slave (
        input  RTC_WE, RTC_ADDR, RTC_DATA, UI_WE, UI_ADDR, UI_DATA, VSync,
        output RTC_ACK, UI_ACK, MemAddrOUT, MemDataOUT, CS_DATA, BUSY
    );
endinterface

// File: rtl/vga_dirty_prienc.sv
// Lowest-set-bit priority encoder over the dirty vector.
//   req   : request vector, bit i = entry i (address i+1)
//   idx   : index of the lowest set bit (0 when none)
//   valid : at least one bit set
module vga_dirty_prienc #(
    parameter int N     = 12,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);
    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        valid = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end
endmodule

// File: rtl/vga_reg_update_sched.sv
// Display-register update scheduler. Two write ports (RTC, UI) update a
// shadow file; dirty entries are streamed lowest-address first, one per
// cycle, to the display pointer block while VSync is low.
//   CLK, RESET : clock, synchronous active-high reset
//   bus        : slave side of vga_reg_update_sched_if (write ports, VSync,
//                registered output stream, BUSY)
// Optional build macro VGA_FULL_REFRESH_EN: entering a window marks every
// entry dirty, so each window resends the whole file in address order.
module vga_reg_update_sched #(
    parameter int NUM_REGS = vga_reg_update_sched_pkg::NUM_REGS,
    parameter int ADDR_W   = vga_reg_update_sched_pkg::ADDR_W
) (
    input  logic                   CLK,
    input  logic                   RESET,
    vga_reg_update_sched_if.slave  bus
);
    import vga_reg_update_sched_pkg::*;

    logic [NUM_REGS-1:0][7:0] shadow;
    logic [NUM_REGS-1:0]      dirty, dirtyNext, setMask, clrMask;
    sched_state_e             state, stateNext;
    logic                     uiAck, rtcAck, emit, enterStream, encValid;
    logic [ADDR_W-1:0]        encIdx, wrAddr, memAddr;
    logic [7:0]               wrData, emitData, memData;
    logic                     csData, busy;

    function automatic logic addrOk(input logic [ADDR_W-1:0] a);
        return (a != '0) && (a <= ADDR_W'(NUM_REGS));
    endfunction

    // UI has priority; RTC must hold its request until it sees its ack.
    assign uiAck  = !RESET && bus.UI_WE && addrOk(bus.UI_ADDR);
    assign rtcAck = !RESET && bus.RTC_WE && addrOk(bus.RTC_ADDR) && !uiAck;

    vga_dirty_prienc #(.N(NUM_REGS), .IDX_W(ADDR_W)) u_prienc (
        .req   (dirty),
        .idx   (encIdx),
        .valid (encValid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        emit        = 1'b0;
        enterStream = 1'b0;
        case (state)
            IDLE: if (!bus.VSync && encValid) begin
                stateNext   = STREAM;
                enterStream = 1'b1;
            end
            // Window closing aborts the stream; leftover dirty bits wait.
            STREAM: if (bus.VSync)     stateNext = IDLE;
                    else if (encValid) emit      = 1'b1;
                    else               stateNext = DONE;
            DONE:   if (bus.VSync)     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A write landing on the entry being emitted keeps it dirty (set wins),
    // so the new value goes out on a later cycle.
    always_comb begin
        wrAddr   = uiAck ? bus.UI_ADDR : bus.RTC_ADDR;
        wrData   = uiAck ? bus.UI_DATA : bus.RTC_DATA;
        setMask  = '0;
        clrMask  = '0;
        emitData = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            setMask[i] = (uiAck || rtcAck) && (wrAddr == ADDR_W'(i + 1));
            clrMask[i] = emit && (encIdx == ADDR_W'(i));
            if (encIdx == ADDR_W'(i)) emitData = shadow[i];
        end
        dirtyNext = (dirty & ~clrMask) | setMask;
`ifdef VGA_FULL_REFRESH_EN
        if (enterStream) dirtyNext = '1;
`else
        if (enterStream) dirtyNext = (dirty & ~clrMask) | setMask;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            shadow  <= '0;
            dirty   <= '0;
            busy    <= 1'b0;
            csData  <= 1'b0;
            memAddr <= '0;
            memData <= '0;
        end else begin
            dirty  <= dirtyNext;
            busy   <= |dirtyNext;
            csData <= emit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (setMask[i]) shadow[i] <= wrData;
            end
            if (emit) begin
                memAddr <= encIdx + ADDR_W'(1);
                memData <= emitData;
            end
        end
    end

    assign bus.UI_ACK     = uiAck;
    assign bus.RTC_ACK    = rtcAck;
    assign bus.CS_DATA    = csData;
    assign bus.MemAddrOUT = memAddr;
    assign bus.MemDataOUT = memData;
    assign bus.BUSY       = busy;

endmodule

// File: tb/tb_vga_reg_update_sched.sv
// Self-checking bench for vga_reg_update_sched. Expected stream entries are
// queued as writes are issued (in address order) and popped by a monitor
// whenever CS_DATA is seen high.
module tb_vga_reg_update_sched;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } emit_t;

    logic  CLK = 1'b0;
    logic  RESET = 1'b1;
    emit_t sbQ[$];
    logic [7:0] mdl [1:12];
    int nCmp = 0;
    int nErr = 0;

    vga_reg_update_sched_if #(.ADDR_W(4)) bus ();

    vga_reg_update_sched u_dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        if (obs !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d);
        emit_t e;
        e.addr = a;
        e.data = d;
        sbQ.push_back(e);
    endtask

    // Single-cycle write request, ack checked before the edge.
    task automatic wrReq(input bit ui, input logic [3:0] a, input logic [7:0] d, input bit expAck);
        if (ui) begin
            bus.UI_WE = 1'b1; bus.UI_ADDR = a; bus.UI_DATA = d;
        end else begin
            bus.RTC_WE = 1'b1; bus.RTC_ADDR = a; bus.RTC_DATA = d;
        end
        #1;
        if (ui) chk("ui_ack", 32'(bus.UI_ACK), 32'(expAck));
        else    chk("rtc_ack", 32'(bus.RTC_ACK), 32'(expAck));
        tick();
        bus.UI_WE  = 1'b0;
        bus.RTC_WE = 1'b0;
        if (expAck) mdl[a] = d;
    endtask

    // Stream monitor: every CS_DATA pulse must match the head of the queue.
    always @(negedge CLK) begin
        if (!RESET && bus.CS_DATA === 1'b1) begin
            if (sbQ.size() == 0) begin
                chk("sb_unexpected", 32'(bus.MemAddrOUT), 32'hFFFF);
            end else begin
                emit_t e;
                e = sbQ.pop_front();
                chk("emit_addr", 32'(bus.MemAddrOUT), 32'(e.addr));
                chk("emit_data", 32'(bus.MemDataOUT), 32'(e.data));
            end
        end
    end

    initial begin
        for (int i = 1; i <= 12; i++) mdl[i] = 8'h00;
        bus.VSync = 1'b1;
        bus.UI_WE = 1'b0; bus.UI_ADDR = 4'd0; bus.UI_DATA = 8'h00;
        // Valid-looking RTC request during reset must not be acked.
        bus.RTC_WE = 1'b1; bus.RTC_ADDR = 4'd1; bus.RTC_DATA = 8'hEE;
        tick();
        chk("rst_rtc_ack", 32'(bus.RTC_ACK), 0);
        tick();
        bus.RTC_WE = 1'b0;
        tick();
        chk("rst_cs", 32'(bus.CS_DATA), 0);
        chk("rst_busy", 32'(bus.BUSY), 0);
        chk("rst_maddr", 32'(bus.MemAddrOUT), 0);
        chk("rst_mdata", 32'(bus.MemDataOUT), 0);
        RESET = 1'b0;
        tick();

        // Open window with nothing dirty: no stream, not busy.
        bus.VSync = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("idle_cs", 32'(bus.CS_DATA), 0);
        chk("idle_busy", 32'(bus.BUSY), 0);
        bus.VSync = 1'b1;
        tick();

        // Out-of-range addresses are never acked or stored.
        wrReq(1'b1, 4'd0,  8'h11, 1'b0);
        wrReq(1'b0, 4'd13, 8'h22, 1'b0);
        wrReq(1'b0, 4'd15, 8'h33, 1'b0);
        chk("bad_addr_busy", 32'(bus.BUSY), 0);

`ifndef VGA_FULL_REFRESH_EN
        // Two RTC writes streamed back-to-back in address order.
        wrReq(1'b0, 4'd1, 8'h59, 1'b1);
        wrReq(1'b0, 4'd2, 8'h34, 1'b1);
        push(4'd1, 8'h59);
        push(4'd2, 8'h34);
        chk("t2_busy_pre", 32'(bus.BUSY), 1);
        bus.VSync = 1'b0;
        tick();
        chk("t2_cs0", 32'(bus.CS_DATA), 0);
        tick();
        chk("t2_cs1", 32'(bus.CS_DATA), 1);
        chk("t2_busy_mid", 32'(bus.BUSY), 1);
        tick();
        chk("t2_cs2", 32'(bus.CS_DATA), 1);
        chk("t2_busy_end", 32'(bus.BUSY), 0);
        tick();
        chk("t2_cs3", 32'(bus.CS_DATA), 0);
        chk("t2_hold_addr", 32'(bus.MemAddrOUT), 2);
        chk("t2_hold_data", 32'(bus.MemDataOUT), 32'h34);
        chk("t2_sb_empty", 32'(sbQ.size()), 0);
        bus.VSync = 1'b1;
        tick();

        // Simultaneous requests: UI wins, RTC holds and is acked next cycle.
        bus.RTC_WE = 1'b1; bus.RTC_ADDR = 4'd3;  bus.RTC_DATA = 8'h12;
        bus.UI_WE  = 1'b1; bus.UI_ADDR  = 4'd12; bus.UI_DATA  = 8'h04;
        #1;
        chk("t3_ui_ack", 32'(bus.UI_ACK), 1);
        chk("t3_rtc_nack", 32'(bus.RTC_ACK), 0);
        tick();
        bus.UI_WE = 1'b0;
        #1;
        chk("t3_rtc_ack", 32'(bus.RTC_ACK), 1);
        tick();
        bus.RTC_WE = 1'b0;
        push(4'd3, 8'h12);
        push(4'd12, 8'h04);
        bus.VSync = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t3_sb_empty", 32'(sbQ.size()), 0);
        bus.VSync = 1'b1;
        tick();

        // Window closes after three entries; the rest go next window.
        for (int i = 1; i <= 6; i++) begin
            wrReq(1'b1, 4'(i), 8'(8'hA0 + i), 1'b1);
            push(4'(i), 8'(8'hA0 + i));
        end
        bus.VSync = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_cs_third", 32'(bus.CS_DATA), 1);
        bus.VSync = 1'b1;
        tick();
        chk("t4_cs_abort", 32'(bus.CS_DATA), 0);
        chk("t4_busy_kept", 32'(bus.BUSY), 1);
        chk("t4_sb_left", 32'(sbQ.size()), 3);
        tick();
        tick();
        bus.VSync = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_sb_empty", 32'(sbQ.size()), 0);
        chk("t4_busy_end", 32'(bus.BUSY), 0);
        bus.VSync = 1'b1;
        tick();

        // Rewrite of the entry being emitted is re-sent with new data.
        wrReq(1'b1, 4'd7, 8'h77, 1'b1);
        push(4'd7, 8'h77);
        bus.VSync = 1'b0;
        tick();
        wrReq(1'b1, 4'd7, 8'h10, 1'b1);
        push(4'd7, 8'h10);
        chk("t5_cs_first", 32'(bus.CS_DATA), 1);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_sb_empty", 32'(sbQ.size()), 0);
        bus.VSync = 1'b1;
        tick();
`endif

        // One dirty entry: default build sends just it, full refresh sends all.
        wrReq(1'b0, 4'd5, 8'h55, 1'b1);
`ifdef VGA_FULL_REFRESH_EN
        for (int i = 1; i <= 12; i++) push(4'(i), mdl[i]);
`else
        push(4'd5, 8'h55);
`endif
        bus.VSync = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("t6_sb_empty", 32'(sbQ.size()), 0);
        chk("t6_cs_done", 32'(bus.CS_DATA), 0);
        chk("t6_busy", 32'(bus.BUSY), 0);
        bus.VSync = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
